riscv_core_irq_gateway: RTL and testbench

//  External-interrupt gateway and arbiter directly upstream of the CSR unit.

---
 rtl/riscv_core_irq_pkg.sv | 13 +
 rtl/riscv_core_irq_src_gateway.sv | 66 ++++++
 rtl/riscv_core_irq_gateway.sv | 103 ++++++++++
 tb/tb_riscv_core_irq_gateway.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_irq_pkg.sv
// Shared types and defaults for the external-interrupt gateway.
// Optional macro: IRQ_GATEWAY_SYNC_EN (per-source input synchronisers).
package riscv_core_irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

    localparam int unsigned IRQ_N_SRC_DEFAULT = 8;

endpackage

// File: rtl/riscv_core_irq_src_gateway.sv
// Per-source gateway: optional synchroniser, edge history, pending and in-service flops.
// IRQ_GATEWAY_SYNC_EN inserts a SYNC_STAGES-deep synchroniser ahead of the qualification logic.
module riscv_core_irq_src_gateway
    import riscv_core_irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_src,
    input  logic i_edge_sel,
    input  logic i_set_claim,
    input  logic i_clr_service,
    output logic o_pending,
    output logic o_in_service
);

    logic w_s;
    logic w_qual;
    logic r_prev;
    logic r_pending;
    logic r_in_service;

`ifdef IRQ_GATEWAY_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_src;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];
`else
    assign w_s = i_src;
`endif

    // Edge sources re-pend even while in service; level sources wait for completion.
    assign w_qual = i_edge_sel ? (w_s & ~r_prev)
                               : (w_s & ~r_pending & ~r_in_service);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev       <= 1'b0;
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_prev    <= w_s;
            r_pending <= w_qual | (r_pending & ~i_set_claim);
            if (i_set_claim) begin
                r_in_service <= 1'b1;
            end else if (i_clr_service) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign o_pending    = r_pending;
    assign o_in_service = r_in_service;

endmodule

// File: rtl/riscv_core_irq_gateway.sv
// External-interrupt gateway: fixed-priority arbiter, claim/complete FSM feeding CSR mexternal.
// Optional macro: IRQ_GATEWAY_SYNC_EN (synchronise raw sources, adds SYNC_STAGES latency).
module riscv_core_irq_gateway
    import riscv_core_irq_pkg::*;
#(
    parameter int unsigned N_SRC       = IRQ_N_SRC_DEFAULT,
    parameter int unsigned ID_W        = $clog2(N_SRC),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_irq_gateway_clk,
    input  logic             i_irq_gateway_rst_n,
    input  logic [N_SRC-1:0] i_irq_gateway_src,
    input  logic [N_SRC-1:0] i_irq_gateway_edge_sel,
    input  logic [N_SRC-1:0] i_irq_gateway_enable,
    output logic             o_irq_gateway_mexternal,
    input  logic             i_irq_gateway_ack,
    output logic             o_irq_gateway_claim_valid,
    output logic [ID_W-1:0]  o_irq_gateway_claim_id,
    input  logic             i_irq_gateway_complete,
    input  logic [ID_W-1:0]  i_irq_gateway_complete_id
);

    irq_state_t       r_state;
    irq_state_t       w_state_next;
    logic [ID_W-1:0]  r_claim_id;
    logic [ID_W-1:0]  w_winner;
    logic             w_any;
    logic             w_claim_go;
    logic [N_SRC-1:0] w_pending;
    logic [N_SRC-1:0] w_in_service;
    logic [N_SRC-1:0] w_set_claim;
    logic [N_SRC-1:0] w_clr_service;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        riscv_core_irq_src_gateway #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_src (
            .i_clk         (i_irq_gateway_clk),
            .i_rst_n       (i_irq_gateway_rst_n),
            .i_src         (i_irq_gateway_src[g]),
            .i_edge_sel    (i_irq_gateway_edge_sel[g]),
            .i_set_claim   (w_set_claim[g]),
            .i_clr_service (w_clr_service[g]),
            .o_pending     (w_pending[g]),
            .o_in_service  (w_in_service[g])
        );
    end

    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!w_any && w_pending[i] && i_irq_gateway_enable[i]) begin
                w_winner = ID_W'(i);
                w_any    = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_claim_go    = 1'b0;
        w_set_claim   = '0;
        w_clr_service = '0;
        case (r_state)
            IRQ_IDLE: begin
                if (w_any) w_state_next = IRQ_ASSERT;
            end
            IRQ_ASSERT: begin
                // Losing every enabled request withdraws the trap, even if acked this cycle.
                if (!w_any) begin
                    w_state_next = IRQ_IDLE;
                end else if (i_irq_gateway_ack) begin
                    w_state_next          = IRQ_SERVICE;
                    w_claim_go            = 1'b1;
                    w_set_claim[w_winner] = 1'b1;
                end
            end
            IRQ_SERVICE: begin
                if (i_irq_gateway_complete && (i_irq_gateway_complete_id == r_claim_id)) begin
                    w_state_next              = IRQ_IDLE;
                    w_clr_service[r_claim_id] = 1'b1;
                end
            end
            default: w_state_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge i_irq_gateway_clk or negedge i_irq_gateway_rst_n) begin
        if (!i_irq_gateway_rst_n) begin
            r_state    <= IRQ_IDLE;
            r_claim_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_claim_go) r_claim_id <= w_winner;
        end
    end

    assign o_irq_gateway_mexternal   = (r_state == IRQ_ASSERT);
    assign o_irq_gateway_claim_valid = |w_in_service;
    assign o_irq_gateway_claim_id    = r_claim_id;

endmodule

// File: tb/tb_riscv_core_irq_gateway.sv
// Self-checking bench for riscv_core_irq_gateway (default build, no source synchroniser).
module tb_riscv_core_irq_gateway;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] src = '0;
    logic [7:0] esel = '0;
    logic [7:0] en = '0;
    logic       ack = 1'b0;
    logic       cmp = 1'b0;
    logic [2:0] cid = '0;
    logic       mext;
    logic       cval;
    logic [2:0] clid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit m_pend [8];
    bit m_svc  [8];
    bit m_prev [8];
    bit m_asserting;
    int m_serving;
    int m_claim_id;

    riscv_core_irq_gateway #(
        .N_SRC       (8),
        .ID_W        (3),
        .SYNC_STAGES (2)
    ) dut (
        .i_irq_gateway_clk         (clk),
        .i_irq_gateway_rst_n       (rst_n),
        .i_irq_gateway_src         (src),
        .i_irq_gateway_edge_sel    (esel),
        .i_irq_gateway_enable      (en),
        .o_irq_gateway_mexternal   (mext),
        .i_irq_gateway_ack         (ack),
        .o_irq_gateway_claim_valid (cval),
        .o_irq_gateway_claim_id    (clid),
        .i_irq_gateway_complete    (cmp),
        .i_irq_gateway_complete_id (cid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_svc[i]  = 0;
            m_prev[i] = 0;
        end
        m_asserting = 0;
        m_serving   = -1;
        m_claim_id  = 0;
    endfunction

    // One clock edge of the gateway rules, from pre-edge state and current inputs.
    function automatic void model_step();
        int win = -1;
        bit nxt [8];
        bit claim;
        for (int i = 0; i < 8; i++)
            if (win < 0 && m_pend[i] && en[i]) win = i;
        claim = m_asserting && (win >= 0) && ack;
        for (int i = 0; i < 8; i++) begin
            bit q;
            q = esel[i] ? (src[i] && !m_prev[i]) : (src[i] && !m_pend[i] && !m_svc[i]);
            nxt[i] = q || (m_pend[i] && !(claim && i == win));
        end
        for (int i = 0; i < 8; i++) m_prev[i] = src[i];
        if (m_asserting) begin
            if (win < 0) m_asserting = 0;
            else if (ack) begin
                m_asserting  = 0;
                m_serving    = win;
                m_claim_id   = win;
                m_svc[win]   = 1;
            end
        end else if (m_serving >= 0) begin
            if (cmp && cid == m_serving[2:0]) begin
                m_svc[m_serving] = 0;
                m_serving        = -1;
            end
        end else if (win >= 0) begin
            m_asserting = 1;
        end
        m_pend = nxt;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("mext", {31'd0, mext}, {31'd0, m_asserting});
        check("cvalid", {31'd0, cval}, (m_serving >= 0) ? 32'd1 : 32'd0);
        check("cid", {29'd0, clid}, m_claim_id);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_cmp(input logic [2:0] id);
        cmp = 1'b1;
        cid = id;
        tick();
        cmp = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mext", {31'd0, mext}, 0);
        check("rst_cval", {31'd0, cval}, 0);
        check("rst_cid", {29'd0, clid}, 0);

        // 1: level src[3] from reset
        src = 8'h08; esel = 8'h00; en = 8'hFF;
        rst_n = 1'b1;
        tick();
        check("t1_mext_early", {31'd0, mext}, 0);
        tick();
        check("t1_mext", {31'd0, mext}, 1);
        pulse_ack();
        check("t1_cid", {29'd0, clid}, 3);
        check("t1_cval", {31'd0, cval}, 1);
        check("t1_mext_ack", {31'd0, mext}, 0);
        src = 8'h00;
        pulse_cmp(3'd3);
        check("t1_done", {31'd0, cval}, 0);
        repeat (2) tick();

        // 2: simultaneous edges on 5 and 2
        esel = 8'h24;
        tick();
        src = 8'h24;
        tick();
        tick();
        pulse_ack();
        check("t2_cid2", {29'd0, clid}, 2);
        src = 8'h00;
        tick();
        pulse_cmp(3'd2);
        tick();
        check("t2_reassert", {31'd0, mext}, 1);
        pulse_ack();
        check("t2_cid5", {29'd0, clid}, 5);
        pulse_cmp(3'd5);
        tick();

        // 3: enable masks arbitration only
        esel = 8'h00; en = 8'hEF; src = 8'h10;
        repeat (2) tick();
        check("t3_masked", {31'd0, mext}, 0);
        en = 8'hFF;
        tick();
        check("t3_enabled", {31'd0, mext}, 1);
        en = 8'hEF;
        tick();
        check("t3_dropped", {31'd0, mext}, 0);
        src = 8'h00; en = 8'hFF;
        tick();
        check("t3_still_pend", {31'd0, mext}, 1);
        pulse_ack();
        check("t3_cid4", {29'd0, clid}, 4);
        pulse_cmp(3'd4);
        tick();

        // 4: mismatched complete and stray ack
        src = 8'h02;
        repeat (2) tick();
        pulse_ack();
        src = 8'h00;
        check("t4_cid1", {29'd0, clid}, 1);
        pulse_cmp(3'd6);
        check("t4_bad_cmp", {31'd0, cval}, 1);
        pulse_ack();
        check("t4_stray_ack_cval", {31'd0, cval}, 1);
        check("t4_stray_ack_cid", {29'd0, clid}, 1);
        pulse_cmp(3'd1);
        tick();

        // 5: edge src[0] pulses twice during service
        esel = 8'h01;
        src = 8'h01; tick();
        src = 8'h00; tick();
        pulse_ack();
        check("t5_cid0", {29'd0, clid}, 0);
        src = 8'h01; tick();
        src = 8'h00; tick();
        src = 8'h01; tick();
        src = 8'h00; tick();
        pulse_cmp(3'd0);
        tick();
        check("t5_reclaim", {31'd0, mext}, 1);
        pulse_ack();
        check("t5_cval", {31'd0, cval}, 1);
        pulse_cmp(3'd0);
        repeat (2) tick();
        check("t5_once", {31'd0, mext}, 0);

        // 6: async reset during service
        esel = 8'h00; src = 8'h08;
        repeat (2) tick();
        pulse_ack();
        check("t6_insvc", {31'd0, cval}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_mext", {31'd0, mext}, 0);
        check("t6_rst_cval", {31'd0, cval}, 0);
        check("t6_rst_cid", {29'd0, clid}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_repend", {31'd0, mext}, 1);
        src = 8'h00;
        pulse_ack();
        pulse_cmp(3'd3);

        // randomized traffic against the model
        for (int blk = 0; blk < 6; blk++) begin
            esel = 8'($urandom);
            for (int c = 0; c < 500; c++) begin
                for (int b = 0; b < 8; b++)
                    if ($urandom_range(7, 0) == 0) src[b] = ~src[b];
                if ($urandom_range(15, 0) == 0) en = 8'($urandom) | 8'($urandom);
                ack = ($urandom_range(2, 0) == 0);
                cmp = ($urandom_range(3, 0) == 0);
                cid = ($urandom_range(3, 0) != 0) ? 3'(m_claim_id) : 3'($urandom);
                tick();
            end
        end
        ack = 1'b0;
        cmp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
